// File: rtl/interface_led_pkg.sv
// Shared constants for the LED peripheral: register map, CTRL bit positions and reset values.
package interface_led_pkg;

    localparam int ADDR_PATTERN = 0;
    localparam int ADDR_BLINK   = 1;
    localparam int ADDR_CTRL    = 2;
    localparam int ADDR_STATUS  = 3;
    localparam int ADDR_DUTY0   = 4;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_INV_BIT = 1;

    localparam logic CTRL_EN_RST     = 1'b1;
    localparam logic CTRL_INV_RST    = 1'b0;
    localparam logic PATTERN_RST_BIT = 1'b0;
    localparam logic BLINK_RST_BIT   = 1'b0;
    // Duty resets to all-ones so a lit channel is fully on without any DUTY write.
    localparam logic DUTY_RST_BIT    = 1'b1;

    function automatic bit addr_is(input int unsigned addr, input int unsigned reg_addr);
        return addr == reg_addr;
    endfunction

endpackage

// File: rtl/interface_led_pwm_if.sv
// CPU write/read bus as seen by the LED peripheral.
interface led_bus_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // Single-cycle strobe bus, no ready: a write happens on every rising edge where we=1,
    // and data_out always shows reg[addr] as sampled on the previous edge.
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output we,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  we,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/led_pwm_channel.sv
// One PWM channel: duty shadow reloaded at period wrap, compared against the shared counter.
module led_pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_on
);
    import interface_led_pkg::*;

    logic [PWM_BITS-1:0] shadow;

    // Duty only changes at a period boundary so a period is never split between two duties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= {PWM_BITS{DUTY_RST_BIT}};
        end else if (wrap) begin
            shadow <= duty;
        end
    end

    // All-ones is special-cased so full duty has no one-cycle gap at the counter maximum.
    assign pwm_on = (&shadow) | (pwm_cnt < shadow);

endmodule

// File: rtl/interface_led_pwm.sv
// Memory-mapped LED driver: pattern/blink/PWM per channel, registered LED drive and readback.
module interface_led_pwm
    import interface_led_pkg::*;
#(
    parameter int NUM_LEDS  = 8,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int PWM_BITS  = 8,
    parameter int BLINK_DIV = 2**22
) (
    input  logic                clk,
    input  logic                rst_n,
    led_bus_if.slave            bus,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam int PRE_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(BLINK_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_RST = {PWM_BITS{DUTY_RST_BIT}};

    logic [NUM_LEDS-1:0] pattern;
    logic [NUM_LEDS-1:0] blink;
    logic                ctrl_en;
    logic                ctrl_inv;
    logic [PWM_BITS-1:0] duty [NUM_LEDS];

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_wrap;
    logic [PRE_W-1:0]    prescaler;
    logic                phase;

    logic [NUM_LEDS-1:0] pwm_on;
    logic [NUM_LEDS-1:0] lit;
    logic [DATA_W-1:0]   rd_data;
    int unsigned         bus_addr;
    logic                unused_data_bits;

    assign bus_addr         = int'(bus.addr);
    assign unused_data_bits = ^bus.data_in;

    // Register file; STATUS and unmapped addresses silently drop writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern  <= {NUM_LEDS{PATTERN_RST_BIT}};
            blink    <= {NUM_LEDS{BLINK_RST_BIT}};
            ctrl_en  <= CTRL_EN_RST;
            ctrl_inv <= CTRL_INV_RST;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty[i] <= DUTY_RST;
            end
        end else if (bus.we) begin
            if (addr_is(bus_addr, ADDR_PATTERN)) begin
                pattern <= bus.data_in[NUM_LEDS-1:0];
            end
            if (addr_is(bus_addr, ADDR_BLINK)) begin
                blink <= bus.data_in[NUM_LEDS-1:0];
            end
            if (addr_is(bus_addr, ADDR_CTRL)) begin
                ctrl_en  <= bus.data_in[CTRL_EN_BIT];
                ctrl_inv <= bus.data_in[CTRL_INV_BIT];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (addr_is(bus_addr, ADDR_DUTY0 + i)) begin
                    duty[i] <= bus.data_in[PWM_BITS-1:0];
                end
            end
        end
    end

    assign pwm_wrap = &pwm_cnt;

    // Both timebases free-run; bus traffic and EN never stall them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            prescaler <= '0;
            phase     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                phase     <= ~phase;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .duty   (duty[g]),
            .wrap   (pwm_wrap),
            .pwm_cnt(pwm_cnt),
            .pwm_on (pwm_on[g])
        );
    end

    assign lit = {NUM_LEDS{ctrl_en}} & pattern & (~blink | {NUM_LEDS{phase}}) & pwm_on;

    always_comb begin
        rd_data = '0;
        if (addr_is(bus_addr, ADDR_PATTERN)) begin
            rd_data = DATA_W'(pattern);
        end else if (addr_is(bus_addr, ADDR_BLINK)) begin
            rd_data = DATA_W'(blink);
        end else if (addr_is(bus_addr, ADDR_CTRL)) begin
            rd_data = DATA_W'({ctrl_inv, ctrl_en});
        end else if (addr_is(bus_addr, ADDR_STATUS)) begin
            rd_data = DATA_W'(phase);
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (addr_is(bus_addr, ADDR_DUTY0 + i)) begin
                    rd_data = DATA_W'(duty[i]);
                end
            end
        end
    end

    // Readback samples the pre-write register, so a same-edge write+read returns the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out      <= '0;
            bus.data_out <= '0;
        end else begin
            led_out      <= lit ^ {NUM_LEDS{ctrl_inv}};
            bus.data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_interface_led_pwm.sv
// Bench for interface_led_pwm: cycle model feeding an expected queue, plus directed scenario checks.
module tb_interface_led_pwm;

    localparam int NUM_LEDS  = 4;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int PWM_BITS  = 4;
    localparam int BLINK_DIV = 4;
    localparam int EXP_W     = NUM_LEDS + DATA_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM_LEDS-1:0] led_out;

    led_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    interface_led_pwm #(
        .NUM_LEDS (NUM_LEDS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PWM_BITS (PWM_BITS),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .led_out(led_out)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Reference state, written from the register-map description
    logic [3:0] m_pattern;
    logic [3:0] m_blink;
    logic       m_en;
    logic       m_inv;
    logic [3:0] m_duty [4];
    logic [3:0] m_shadow [4];
    logic [3:0] m_cnt;
    int         m_pre;
    logic       m_phase;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pattern = 4'h0;
        m_blink   = 4'h0;
        m_en      = 1'b1;
        m_inv     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_duty[i]   = 4'hF;
            m_shadow[i] = 4'hF;
        end
        m_cnt   = 4'h0;
        m_pre   = 0;
        m_phase = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:                model_read = {4'h0, m_pattern};
            4'd1:                model_read = {4'h0, m_blink};
            4'd2:                model_read = {6'h0, m_inv, m_en};
            4'd3:                model_read = {7'h0, m_phase};
            4'd4, 4'd5, 4'd6, 4'd7: model_read = {4'h0, m_duty[a - 4'd4]};
            default:             model_read = 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] model_led();
        logic [3:0] lit;
        for (int i = 0; i < 4; i++) begin
            lit[i] = m_en & m_pattern[i] & (~m_blink[i] | m_phase)
                     & ((m_shadow[i] == 4'hF) | (m_cnt < m_shadow[i]));
        end
        return lit ^ {4{m_inv}};
    endfunction

    task automatic model_edge(input logic w, input logic [3:0] a, input logic [7:0] d);
        if (m_cnt == 4'hF) begin
            for (int i = 0; i < 4; i++) m_shadow[i] = m_duty[i];
        end
        if (w) begin
            case (a)
                4'd0: m_pattern = d[3:0];
                4'd1: m_blink   = d[3:0];
                4'd2: begin m_en = d[0]; m_inv = d[1]; end
                4'd4, 4'd5, 4'd6, 4'd7: m_duty[a - 4'd4] = d[3:0];
                default: ;
            endcase
        end
        m_cnt = m_cnt + 4'h1;
        if (m_pre == BLINK_DIV - 1) begin
            m_pre   = 0;
            m_phase = ~m_phase;
        end else begin
            m_pre++;
        end
    endtask

    // Driver: one bus cycle; expectation queued at drive time, checked after the edge
    task automatic step(input logic w, input logic [3:0] a, input logic [7:0] d);
        logic [EXP_W-1:0] exp_v;
        bus.we      = w;
        bus.addr    = a;
        bus.data_in = d;
        exp_q.push_back({model_led(), model_read(a)});
        model_edge(w, a, d);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        exp_v = exp_q.pop_front();
        check_eq("sb_led_out", 32'(led_out), 32'(exp_v[EXP_W-1:DATA_W]));
        check_eq("sb_data_out", 32'(bus.data_out), 32'(exp_v[DATA_W-1:0]));
    endtask

    task automatic idle(input int n, input logic [3:0] a);
        for (int i = 0; i < n; i++) step(1'b0, a, 8'h00);
    endtask

    task automatic count_led0(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 4'd0, 8'h00);
            ones += int'(led_out[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ones;
        int bad;
        int same;
        logic [15:0] led_hist;
        logic [15:0] sts_hist;

        rst_n       = 1'b0;
        bus.we      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("init_led", 32'(led_out), 32'h0);
        check_eq("init_dout", 32'(bus.data_out), 32'h0);
        rst_n = 1'b1;

        step(1'b0, 4'd2, 8'h00);
        check_eq("rst_ctrl_rd", 32'(bus.data_out), 32'h01);
        step(1'b0, 4'd4, 8'h00);
        check_eq("rst_duty0_rd", 32'(bus.data_out), 32'h0F);

        // Static pattern and inversion
        step(1'b1, 4'd0, 8'h0A);
        step(1'b0, 4'd0, 8'h00);
        check_eq("static_pat", 32'(led_out), 32'hA);
        step(1'b1, 4'd2, 8'h03);
        step(1'b0, 4'd0, 8'h00);
        check_eq("static_inv", 32'(led_out), 32'h5);
        step(1'b1, 4'd2, 8'h02);
        step(1'b0, 4'd0, 8'h00);
        check_eq("en0_inv_level", 32'(led_out), 32'hF);
        step(1'b1, 4'd2, 8'h01);

        // PWM duty sweep on channel 0
        step(1'b1, 4'd0, 8'h01);
        step(1'b1, 4'd4, 8'h04);
        idle(20, 4'd4);
        count_led0(16, ones);
        check_eq("pwm_duty4", 32'(ones), 32'd4);
        step(1'b1, 4'd4, 8'h00);
        idle(20, 4'd4);
        count_led0(16, ones);
        check_eq("pwm_duty0", 32'(ones), 32'd0);
        step(1'b1, 4'd4, 8'h0F);
        idle(20, 4'd4);
        count_led0(16, ones);
        check_eq("pwm_duty15", 32'(ones), 32'd16);

        // Duty written mid-period at pwm_cnt=7
        for (int i = 0; i < 16; i++) begin
            if (m_cnt != 4'd7) step(1'b0, 4'd0, 8'h00);
        end
        step(1'b1, 4'd4, 8'h04);
        count_led0(8, ones);
        check_eq("shadow_old_holds", 32'(ones), 32'd8);
        count_led0(16, ones);
        check_eq("shadow_new_applies", 32'(ones), 32'd4);

        // Blink with STATUS readback
        step(1'b1, 4'd4, 8'h0F);
        step(1'b1, 4'd1, 8'h01);
        idle(20, 4'd3);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 4'd3, 8'h00);
            led_hist[k] = led_out[0];
            sts_hist[k] = bus.data_out[0];
        end
        ones = 0;
        bad  = 0;
        same = 0;
        for (int k = 0; k < 16; k++) begin
            ones += int'(led_hist[k]);
            if (led_hist[k] == sts_hist[k]) same++;
            if (k >= 4 && led_hist[k] == led_hist[k-4]) bad++;
        end
        check_eq("blink_duty", 32'(ones), 32'd8);
        check_eq("blink_toggle4", 32'(bad), 32'd0);
        check_eq("status_phase", 32'(same), 32'd16);
        step(1'b1, 4'd2, 8'h00);
        step(1'b0, 4'd0, 8'h00);
        count_led0(8, ones);
        check_eq("en0_off", 32'(ones), 32'd0);
        step(1'b1, 4'd2, 8'h01);
        step(1'b1, 4'd1, 8'h00);

        // Bus edge cases
        step(1'b1, 4'd3, 8'hFF);
        step(1'b1, 4'd15, 8'hFF);
        step(1'b1, 4'd9, 8'hFF);
        step(1'b0, 4'd15, 8'h00);
        check_eq("rd_unmapped_f", 32'(bus.data_out), 32'h00);
        step(1'b0, 4'd9, 8'h00);
        check_eq("rd_unmapped_9", 32'(bus.data_out), 32'h00);
        step(1'b0, 4'd2, 8'h00);
        check_eq("ctrl_kept", 32'(bus.data_out), 32'h01);
        step(1'b0, 4'd0, 8'h00);
        check_eq("pattern_kept", 32'(bus.data_out), 32'h01);
        step(1'b1, 4'd0, 8'h06);
        check_eq("wr_rd_old", 32'(bus.data_out), 32'h01);
        step(1'b0, 4'd0, 8'h00);
        check_eq("wr_rd_new", 32'(bus.data_out), 32'h06);
        step(1'b1, 4'd0, 8'hF5);
        step(1'b0, 4'd0, 8'h00);
        check_eq("pattern_hibits", 32'(bus.data_out), 32'h05);

        // Random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end

        // Mid-run asynchronous reset with everything lit
        for (int a = 4; a < 8; a++) step(1'b1, 4'(a), 8'h0F);
        step(1'b1, 4'd1, 8'h00);
        step(1'b1, 4'd2, 8'h01);
        step(1'b1, 4'd0, 8'h0F);
        idle(20, 4'd2);
        check_eq("pre_rst_led", 32'(led_out), 32'hF);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_led", 32'(led_out), 32'h0);
        check_eq("midrst_dout", 32'(bus.data_out), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        step(1'b0, 4'd2, 8'h00);
        check_eq("midrst_ctrl_rd", 32'(bus.data_out), 32'h01);
        step(1'b0, 4'd4, 8'h00);
        check_eq("midrst_duty0_rd", 32'(bus.data_out), 32'h0F);
        step(1'b1, 4'd0, 8'h01);
        step(1'b1, 4'd4, 8'h04);
        step(1'b1, 4'd1, 8'h01);
        idle(40, 4'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
